tx_status_irq_ctrl: RTL and testbench

//  Interrupt/occupancy controller for the 32-bit x 64-entry TX status FIFO in tx_intf.

---
 rtl/tx_status_irq_ctrl_if.sv | 40 ++++
 rtl/tx_status_irq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tx_status_irq_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_status_irq_ctrl_if.sv
// rtl/tx_status_irq_ctrl_if.sv - status FIFO strobe / IRQ bundle for tx_status_irq_ctrl
//
// Purpose:
//   Groups the status FIFO strobes, the software ack and the controller's
//   observable outputs into one bundle.
// Signals:
//   fifo_wren        master->slave  status FIFO write strobe
//   fifo_rden        master->slave  status FIFO read strobe (AXI pop)
//   irq_ack          master->slave  1-cycle software ack pulse
//   tx_status_irq    slave->master  level interrupt to PS
//   pending_count    slave->master  shadowed FIFO occupancy
//   overflow_sticky  slave->master  write-while-full flag
interface tx_status_irq_ctrl_if #(
  parameter int CNT_WIDTH = 7
);
  logic                 fifo_wren;
  logic                 fifo_rden;
  logic                 irq_ack;
  logic                 tx_status_irq;
  logic [CNT_WIDTH-1:0] pending_count;
  logic                 overflow_sticky;

  modport master (
    output fifo_wren,
    output fifo_rden,
    output irq_ack,
    input  tx_status_irq,
    input  pending_count,
    input  overflow_sticky
  );

  modport slave (
    input  fifo_wren,
    input  fifo_rden,
    input  irq_ack,
    output tx_status_irq,
    output pending_count,
    output overflow_sticky
  );
endinterface

// File: rtl/tx_status_irq_ctrl.sv
// rtl/tx_status_irq_ctrl.sv - TX status FIFO occupancy shadow and IRQ coalescing controller
//
// Purpose:
//   Shadows the occupancy of the 32-bit x 64-entry TX status FIFO from its
//   write/read strobes. Coalesces entries into one level IRQ that fires on an
//   entry-count threshold or a coalescing timeout. After a software ack, the
//   IRQ is held off for HOLDOFF_CYCLES. Writes into a full FIFO set a sticky
//   overflow flag.
// Ports:
//   clk                 in   clock
//   rstn                in   synchronous active-low reset
//   bus                 slave modport of tx_status_irq_ctrl_if (strobes, ack, irq, count, sticky)
//   i_cfg_irq_en        in   1 = IRQ generation enabled
//   i_cfg_irq_thresh    in   fire when count >= thresh (0 behaves as 1)
//   i_cfg_irq_timeout   in   fire when coalescing timer reaches this value
//   o_drop_count        out  writes lost to overflow, saturating (TX_STATUS_IRQ_STATS_EN only)
//   o_irq_count         out  number of IRQ assertions, wrapping (TX_STATUS_IRQ_STATS_EN only)
// Configuration:
//   TX_STATUS_IRQ_STATS_EN  when defined, adds the drop/irq statistics counters and ports.
module tx_status_irq_ctrl #(
  parameter int FIFO_DEPTH     = 64,
  parameter int CNT_WIDTH      = 7,
  parameter int TIMER_WIDTH    = 16,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  tx_status_irq_ctrl_if.slave    bus,
  input  logic                   i_cfg_irq_en,
  input  logic [CNT_WIDTH-1:0]   i_cfg_irq_thresh,
`ifdef TX_STATUS_IRQ_STATS_EN
  input  logic [TIMER_WIDTH-1:0] i_cfg_irq_timeout,
  output logic [15:0]            o_drop_count,
  output logic [15:0]            o_irq_count
`else
  input  logic [TIMER_WIDTH-1:0] i_cfg_irq_timeout
`endif
);

  localparam int HO_WIDTH = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [HO_WIDTH-1:0]  HO_LAST_C = HO_WIDTH'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_IRQ     = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_ovf;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [TIMER_WIDTH-1:0] w_timer_nxt;
  logic [HO_WIDTH-1:0]    r_holdoff;
  logic [HO_WIDTH-1:0]    w_holdoff_nxt;
  logic                   w_irq_enter;

  logic                   w_inc;
  logic                   w_dec;
  logic                   w_full;
  logic                   w_ovf_set;
  logic                   w_nonzero;
  logic [CNT_WIDTH-1:0]   w_eff_thresh;

  assign w_full    = (r_count == DEPTH_C);
  assign w_nonzero = (r_count != '0);
  // Simultaneous push/pop cancels except at the rails, where only the legal
  // half of the pair takes effect; inc/dec gating alone yields that.
  assign w_inc     = bus.fifo_wren & ~w_full;
  assign w_dec     = bus.fifo_rden & w_nonzero;
  assign w_ovf_set = bus.fifo_wren & ~bus.fifo_rden & w_full;
  assign w_eff_thresh = (i_cfg_irq_thresh == '0) ? CNT_WIDTH'(1) : i_cfg_irq_thresh;

  // Occupancy shadow and overflow flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_inc && !w_dec) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (w_dec && !w_inc) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
      // A new overflow in the ack cycle must not be lost.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (bus.irq_ack) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FSM state register plus its timers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_holdoff <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_holdoff <= w_holdoff_nxt;
    end
  end

  // Next-state logic; everything is evaluated on the registered count
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_holdoff_nxt = r_holdoff;
    w_irq_enter   = 1'b0;
    if (!i_cfg_irq_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_nonzero) begin
            w_state_nxt = S_COLLECT;
            w_timer_nxt = '0;
          end
        end
        S_COLLECT: begin
          if (r_timer != '1) begin
            w_timer_nxt = r_timer + TIMER_WIDTH'(1);
          end
          if ((r_count >= w_eff_thresh) || (r_timer >= i_cfg_irq_timeout)) begin
            w_state_nxt = S_IRQ;
            w_irq_enter = 1'b1;
          end else if (!w_nonzero) begin
            // Software drained the FIFO by polling; nothing left to report.
            w_state_nxt = S_IDLE;
          end
        end
        S_IRQ: begin
          if (bus.irq_ack) begin
            w_state_nxt   = S_HOLDOFF;
            w_holdoff_nxt = '0;
          end
        end
        S_HOLDOFF: begin
          if (r_holdoff == HO_LAST_C) begin
            if (w_nonzero) begin
              w_state_nxt = S_COLLECT;
              w_timer_nxt = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_holdoff_nxt = r_holdoff + HO_WIDTH'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_status_irq   = (r_state == S_IRQ);
  assign bus.pending_count   = r_count;
  assign bus.overflow_sticky = r_ovf;

`ifdef TX_STATUS_IRQ_STATS_EN
  logic [15:0] r_drop_count;
  logic [15:0] r_irq_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_drop_count <= '0;
      r_irq_count  <= '0;
    end else begin
      if (w_ovf_set && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_irq_enter) begin
        r_irq_count <= r_irq_count + 16'd1;
      end
    end
  end

  assign o_drop_count = r_drop_count;
  assign o_irq_count  = r_irq_count;
`else
  // Keeps the enter strobe referenced when the statistics block is absent.
  logic w_unused;
  assign w_unused = w_irq_enter;
`endif

endmodule

// File: tb/tb_tx_status_irq_ctrl.sv
// tb/tb_tx_status_irq_ctrl.sv - directed self-checking bench for tx_status_irq_ctrl
module tb_tx_status_irq_ctrl;

  logic        clk;
  logic        rstn;
  logic        cfg_en;
  logic [6:0]  cfg_thresh;
  logic [15:0] cfg_timeout;
`ifdef TX_STATUS_IRQ_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] irq_count;
`endif

  int n_checks;
  int n_pass;

  tx_status_irq_ctrl_if #(.CNT_WIDTH(7)) bus ();

  tx_status_irq_ctrl #(
    .FIFO_DEPTH(64), .CNT_WIDTH(7), .TIMER_WIDTH(16), .HOLDOFF_CYCLES(16)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .bus              (bus),
    .i_cfg_irq_en     (cfg_en),
    .i_cfg_irq_thresh (cfg_thresh),
`ifdef TX_STATUS_IRQ_STATS_EN
    .i_cfg_irq_timeout(cfg_timeout),
    .o_drop_count     (drop_count),
    .o_irq_count      (irq_count)
`else
    .i_cfg_irq_timeout(cfg_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic rd, input logic ack);
    bus.fifo_wren = wr;
    bus.fifo_rden = rd;
    bus.irq_ack   = ack;
    step();
    bus.fifo_wren = 1'b0;
    bus.fifo_rden = 1'b0;
    bus.irq_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.fifo_wren = 1'b0;
    bus.fifo_rden = 1'b0;
    bus.irq_ack   = 1'b0;
    cfg_en      = 1'b0;
    cfg_thresh  = 7'd4;
    cfg_timeout = 16'd1000;
    rstn        = 1'b0;
    #2;
    do_reset();
    check("rst_irq", 32'(bus.tx_status_irq), 0);
    check("rst_count", 32'(bus.pending_count), 0);
    check("rst_sticky", 32'(bus.overflow_sticky), 0);
`ifdef TX_STATUS_IRQ_STATS_EN
    check("rst_drop", 32'(drop_count), 0);
    check("rst_irqcnt", 32'(irq_count), 0);
`endif

    // Threshold fire: 4 entries, thresh 4
    cfg_en = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0);
    check("thr_count", 32'(bus.pending_count), 4);
    check("thr_irq_early", 32'(bus.tx_status_irq), 0);
    step();
    check("thr_irq", 32'(bus.tx_status_irq), 1);

    // Count dropping does not deassert; ack starts holdoff, then re-fire
    cfg_thresh = 7'd2;
    push(1'b0, 1'b1, 1'b0);
    check("irq_hold_count", 32'(bus.pending_count), 3);
    check("irq_hold", 32'(bus.tx_status_irq), 1);
    push(1'b0, 1'b0, 1'b1);
    check("ack_low", 32'(bus.tx_status_irq), 0);
    for (int i = 0; i < 16; i++) begin
      step();
      check("holdoff_low", 32'(bus.tx_status_irq), 0);
    end
    step();
    check("refire", 32'(bus.tx_status_irq), 1);
    check("refire_count", 32'(bus.pending_count), 3);

    // Timeout fire: thresh 8, timeout 20, single entry
    cfg_en = 1'b0;
    do_reset();
    cfg_en      = 1'b1;
    cfg_thresh  = 7'd8;
    cfg_timeout = 16'd20;
    push(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) step();
    check("tmo_early", 32'(bus.tx_status_irq), 0);
    step();
    check("tmo_irq", 32'(bus.tx_status_irq), 1);
    check("tmo_count", 32'(bus.pending_count), 1);

    // Timeout 0 fires on first COLLECT evaluation
    cfg_en = 1'b0;
    do_reset();
    cfg_en      = 1'b1;
    cfg_timeout = 16'd0;
    push(1'b1, 1'b0, 1'b0);
    step();
    check("tmo0_collect", 32'(bus.tx_status_irq), 0);
    step();
    check("tmo0_irq", 32'(bus.tx_status_irq), 1);

    // Simultaneous push/pop at 0, 5 and 64
    cfg_en      = 1'b0;
    cfg_timeout = 16'd1000;
    do_reset();
    push(1'b1, 1'b1, 1'b0);
    check("both_at0", 32'(bus.pending_count), 1);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    check("both_at5", 32'(bus.pending_count), 5);
    for (int i = 0; i < 59; i++) push(1'b1, 1'b0, 1'b0);
    check("fill64", 32'(bus.pending_count), 64);
    push(1'b1, 1'b1, 1'b0);
    check("both_at64", 32'(bus.pending_count), 63);
    check("both_no_ovf", 32'(bus.overflow_sticky), 0);

    // Overflow handling
    push(1'b1, 1'b0, 1'b0);
    check("full_again", 32'(bus.pending_count), 64);
    check("full_no_ovf", 32'(bus.overflow_sticky), 0);
    push(1'b1, 1'b0, 1'b0);
    check("ovf_sticky", 32'(bus.overflow_sticky), 1);
    check("ovf_count", 32'(bus.pending_count), 64);
`ifdef TX_STATUS_IRQ_STATS_EN
    check("ovf_drop1", 32'(drop_count), 1);
`endif
    push(1'b1, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(bus.overflow_sticky), 1);
`ifdef TX_STATUS_IRQ_STATS_EN
    check("ovf_drop2", 32'(drop_count), 2);
`endif
    push(1'b0, 1'b0, 1'b1);
    check("ack_clears", 32'(bus.overflow_sticky), 0);
    check("ack_idle_irq", 32'(bus.tx_status_irq), 0);

    // Reset during COLLECT with sticky set
    push(1'b1, 1'b0, 1'b0);
    cfg_en     = 1'b1;
    cfg_thresh = 7'd127;
    step();
    step();
    check("pre_rst_sticky", 32'(bus.overflow_sticky), 1);
    check("pre_rst_collect", 32'(bus.tx_status_irq), 0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("mid_rst_irq", 32'(bus.tx_status_irq), 0);
    check("mid_rst_count", 32'(bus.pending_count), 0);
    check("mid_rst_sticky", 32'(bus.overflow_sticky), 0);
`ifdef TX_STATUS_IRQ_STATS_EN
    check("mid_rst_drop", 32'(drop_count), 0);
`endif

    // Disable while IRQ; thresh 0 behaves as 1
    cfg_thresh = 7'd0;
    push(1'b1, 1'b0, 1'b0);
    step();
    step();
    check("thr0_irq", 32'(bus.tx_status_irq), 1);
`ifdef TX_STATUS_IRQ_STATS_EN
    check("irqcnt1", 32'(irq_count), 1);
`endif
    cfg_en = 1'b0;
    step();
    check("dis_irq_low", 32'(bus.tx_status_irq), 0);
    check("dis_count", 32'(bus.pending_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
